// File: rtl/sdr_16_rd_capture.sv
// sdr_16_rd_capture: read-data return stage of the 16-bit SDR SDRAM controller.
// Tracks each read strobe through command register, CAS latency and input pad
// stages, packs the two 16-bit beats of a burst-of-2 into one 32-bit word and
// hands it to the egress FIFO.
// Optional skid buffer: define SDR16_RD_SKID_EN to absorb egress back-pressure
// (output latency L+2); without it words meeting fifo_full are dropped (L+1).
module sdr_16_rd_capture #(
  parameter int cl         = 2,
  parameter int in_lat     = 1,
  parameter int skid_depth = 4
) (
  input  logic        sdram_clk,
  input  logic        sdram_rst,
  input  logic        cmd_read,
  input  logic [15:0] dq_i,
  input  logic        fifo_full,
  input  logic        ovf_clr,
  output logic        fifo_wr,
  output logic [31:0] fifo_dat,
  output logic        rd_busy,
  output logic        ovf,
  output logic        err
);

  // command register + CAS latency + input pad stages
  localparam int L = 1 + cl + in_lat;

  if (cl < 2 || cl > 3 || in_lat < 0 || in_lat > 2 || skid_depth < 2 ||
      (skid_depth & (skid_depth - 1)) != 0) begin : g_bad_param
    $error("sdr_16_rd_capture: illegal parameter value");
  end

  logic [L+1:1] dl;         // tap k high => accepted read sampled k-1 edges ago
  logic         cmd_q;      // raw cmd_read of the previous cycle
  logic         cmd_ok;
  logic         err_set;
  logic         ovf_set;
  logic         cap_busy;
  logic [15:0]  hi_q;
  logic         word_done;
  logic [31:0]  word;

  // A pulse directly after another one is illegal and never enters the pipe.
  assign cmd_ok    = cmd_read & ~cmd_q;
  assign err_set   = cmd_read & cmd_q;
  assign word_done = dl[L+1];
  assign word      = {hi_q, dq_i};

  // Read-strobe delay line.
  always_ff @(posedge sdram_clk or posedge sdram_rst) begin
    if (sdram_rst) begin
      cmd_q <= 1'b0;
      dl    <= '0;
    end else begin
      cmd_q <= cmd_read;
      dl    <= {dl[L:1], cmd_ok};
    end
  end

  // Beat0 capture into the high half; flag marks a half-built word.
  always_ff @(posedge sdram_clk or posedge sdram_rst) begin
    if (sdram_rst) begin
      hi_q     <= '0;
      cap_busy <= 1'b0;
    end else begin
      if (dl[L]) begin
        hi_q     <= dq_i;
        cap_busy <= 1'b1;
      end else if (word_done) begin
        cap_busy <= 1'b0;
      end
    end
  end

  // Sticky flags; a set event in the same cycle as ovf_clr takes priority.
  always_ff @(posedge sdram_clk or posedge sdram_rst) begin
    if (sdram_rst) begin
      ovf <= 1'b0;
      err <= 1'b0;
    end else begin
      if (ovf_set)      ovf <= 1'b1;
      else if (ovf_clr) ovf <= 1'b0;
      if (err_set)      err <= 1'b1;
      else if (ovf_clr) err <= 1'b0;
    end
  end

`ifdef SDR16_RD_SKID_EN
  localparam int PW = $clog2(skid_depth);

  logic [31:0]   mem [skid_depth];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [PW:0]   cnt;
  logic          empty;
  logic          full;
  logic          drain;
  logic          push;

  assign empty   = (cnt == '0);
  assign full    = (cnt == (PW+1)'(skid_depth));
  // A draining head frees a slot in the same edge, so a full buffer still accepts.
  assign drain   = ~empty & ~fifo_full;
  assign push    = word_done & (~full | drain);
  assign ovf_set = word_done & full & ~drain;
  assign rd_busy = (|dl) | cap_busy | ~empty;

  // Skid pointers, occupancy and registered egress write.
  always_ff @(posedge sdram_clk or posedge sdram_rst) begin
    if (sdram_rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      cnt      <= '0;
      fifo_wr  <= 1'b0;
      fifo_dat <= '0;
    end else begin
      fifo_wr <= drain;
      if (drain) begin
        fifo_dat <= mem[rd_ptr];
        rd_ptr   <= rd_ptr + 1'b1;
      end
      if (push) wr_ptr <= wr_ptr + 1'b1;
      case ({push, drain})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end

  // Storage array; contents are don't-care while the slot is unoccupied.
  always_ff @(posedge sdram_clk) begin
    if (push) mem[wr_ptr] <= word;
  end
`else
  assign ovf_set = word_done & fifo_full;
  assign rd_busy = (|dl) | cap_busy;

  // Direct egress write at the beat1 edge; a full FIFO loses the word.
  always_ff @(posedge sdram_clk or posedge sdram_rst) begin
    if (sdram_rst) begin
      fifo_wr  <= 1'b0;
      fifo_dat <= '0;
    end else begin
      fifo_wr <= word_done & ~fifo_full;
      if (word_done & ~fifo_full) fifo_dat <= word;
    end
  end
`endif

endmodule

// File: tb/tb_sdr_16_rd_capture.sv
// Testbench for sdr_16_rd_capture (cl=2, in_lat=1 => L=4); scoreboard based.
`timescale 1ns/1ps
module tb_sdr_16_rd_capture;
  localparam int CL     = 2;
  localparam int IN_LAT = 1;
  localparam int SKID   = 4;
  localparam int L      = 1 + CL + IN_LAT;
`ifdef SDR16_RD_SKID_EN
  localparam int LAT = L + 2;
`else
  localparam int LAT = L + 1;
`endif

  logic        sdram_clk = 1'b0;
  logic        sdram_rst = 1'b1;
  logic        cmd_read  = 1'b0;
  logic [15:0] dq_i      = '0;
  logic        fifo_full = 1'b0;
  logic        ovf_clr   = 1'b0;
  logic        fifo_wr;
  logic [31:0] fifo_dat;
  logic        rd_busy;
  logic        ovf;
  logic        err;

  int n_chk  = 0;
  int n_fail = 0;
  int cyc    = 0;
  int wr_cnt = 0;

  typedef struct {
    logic [31:0] w;
    int          c;   // expected write cycle, 0 = not timed
  } exp_t;
  exp_t sb[$];
  exp_t e_mon;

  sdr_16_rd_capture #(.cl(CL), .in_lat(IN_LAT), .skid_depth(SKID)) dut (
    .sdram_clk (sdram_clk),
    .sdram_rst (sdram_rst),
    .cmd_read  (cmd_read),
    .dq_i      (dq_i),
    .fifo_full (fifo_full),
    .ovf_clr   (ovf_clr),
    .fifo_wr   (fifo_wr),
    .fifo_dat  (fifo_dat),
    .rd_busy   (rd_busy),
    .ovf       (ovf),
    .err       (err)
  );

  always #5 sdram_clk = ~sdram_clk;
  always @(posedge sdram_clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // One legal read: strobe, then play the two beats at the SDRAM return slots.
  task automatic rd(input logic [15:0] h, input logic [15:0] l, input bit keep, input bit timed);
    int   t;
    exp_t e;
    cmd_read = 1'b1;
    @(posedge sdram_clk); #1;
    cmd_read = 1'b0;
    t = cyc;
    if (keep) begin
      e.w = {h, l};
      e.c = timed ? t + LAT : 0;
      sb.push_back(e);
    end
    repeat (L - 1) @(posedge sdram_clk);
    #1 dq_i = h;
    @(posedge sdram_clk);
    #1 dq_i = l;
    @(posedge sdram_clk);
    #1;
  endtask

  task automatic pulse_clr();
    @(posedge sdram_clk); #1 ovf_clr = 1'b1;
    @(posedge sdram_clk); #1 ovf_clr = 1'b0;
    @(negedge sdram_clk);
  endtask

  // Egress monitor: every write must match the oldest outstanding expectation.
  always @(negedge sdram_clk) begin
    if (fifo_wr === 1'b1) begin
      wr_cnt++;
      chk("sb_nonempty_at_wr", 32'(sb.size() > 0), 1);
      if (sb.size() > 0) begin
        e_mon = sb.pop_front();
        chk("fifo_dat", fifo_dat, e_mon.w);
        if (e_mon.c != 0) chk("wr_cycle", cyc, e_mon.c);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int w0;
    int t;

    // reset values
    repeat (3) @(posedge sdram_clk);
    @(negedge sdram_clk);
    chk("rst_fifo_wr", fifo_wr, 0);
    chk("rst_fifo_dat", fifo_dat, 0);
    chk("rst_rd_busy", rd_busy, 0);
    chk("rst_ovf", ovf, 0);
    chk("rst_err", err, 0);
    @(posedge sdram_clk); #1 sdram_rst = 1'b0;
    repeat (2) @(posedge sdram_clk); #1;

    // single read
    w0 = wr_cnt;
    rd(16'hA5A5, 16'h5A5A, 1'b1, 1'b1);
    repeat (4) @(posedge sdram_clk);
    @(negedge sdram_clk);
    chk("single_wr_count", wr_cnt - w0, 1);
    chk("single_ovf", ovf, 0);
    chk("single_err", err, 0);
    chk("single_idle", rd_busy, 0);

    // back-to-back reads every 2 cycles
    @(posedge sdram_clk); #1;
    w0 = wr_cnt;
    for (int i = 0; i < 8; i++) begin
      automatic logic [15:0] b = 16'h1000 + 16'(2 * i);
      fork
        rd(b, b + 16'd1, 1'b1, 1'b1);
      join_none
      @(posedge sdram_clk);
      @(posedge sdram_clk); #1;
    end
    repeat (L + 6) @(posedge sdram_clk);
    @(negedge sdram_clk);
    chk("b2b_wr_count", wr_cnt - w0, 8);
    chk("b2b_ovf", ovf, 0);
    chk("b2b_err", err, 0);
    chk("b2b_sb_empty", sb.size(), 0);

    // back-pressure
    @(posedge sdram_clk); #1;
    w0 = wr_cnt;
`ifdef SDR16_RD_SKID_EN
    fifo_full = 1'b1;
    for (int i = 0; i < 6; i++) begin
      automatic logic [15:0] b = 16'h2000 + 16'(2 * i);
      fork
        rd(b, b + 16'd1, i < 4, 1'b0);
      join_none
      @(posedge sdram_clk);
      @(posedge sdram_clk); #1;
    end
    repeat (L + 1) @(posedge sdram_clk);
    @(negedge sdram_clk);
    chk("bp_ovf_set", ovf, 1);
    chk("bp_no_wr_while_full", wr_cnt - w0, 0);
    chk("bp_busy_buffered", rd_busy, 1);
    @(posedge sdram_clk); #1 fifo_full = 1'b0;
    repeat (10) @(posedge sdram_clk);
    @(negedge sdram_clk);
    chk("bp_drain_count", wr_cnt - w0, 4);
    chk("bp_sb_empty", sb.size(), 0);
    chk("bp_idle", rd_busy, 0);
    pulse_clr();
    chk("bp_ovf_cleared", ovf, 0);
`else
    fifo_full = 1'b1;
    ovf_clr   = 1'b1;   // held across the drop edge: the set must win
    rd(16'hDEAD, 16'hBEEF, 1'b0, 1'b0);
    fifo_full = 1'b0;
    ovf_clr   = 1'b0;
    @(negedge sdram_clk);
    chk("bp_ovf_set_wins", ovf, 1);
    chk("bp_no_wr", wr_cnt - w0, 0);
    pulse_clr();
    chk("bp_ovf_cleared", ovf, 0);
`endif

    // protocol violation: strobes on two consecutive edges
    @(posedge sdram_clk); #1;
    w0 = wr_cnt;
    cmd_read = 1'b1;
    @(posedge sdram_clk); #1;
    t = cyc;
    sb.push_back('{w: 32'h3C3CC3C3, c: t + LAT});
    @(posedge sdram_clk); #1 cmd_read = 1'b0;
    repeat (L - 2) @(posedge sdram_clk);
    #1 dq_i = 16'h3C3C;
    @(posedge sdram_clk); #1 dq_i = 16'hC3C3;
    @(posedge sdram_clk); #1 dq_i = 16'hFFFF;
    repeat (L + 4) @(posedge sdram_clk);
    @(negedge sdram_clk);
    chk("proto_err", err, 1);
    chk("proto_one_word", wr_cnt - w0, 1);
    chk("proto_ovf", ovf, 0);
    pulse_clr();
    chk("proto_err_cleared", err, 0);

    // reset between beat0 and beat1
    @(posedge sdram_clk); #1;
    w0 = wr_cnt;
    fork
      rd(16'h1111, 16'h2222, 1'b0, 1'b0);
    join_none
    repeat (L + 1) @(posedge sdram_clk);
    #1;
    chk("mid_busy", rd_busy, 1);
    #1 sdram_rst = 1'b1;
    @(negedge sdram_clk);
    chk("mid_rst_fifo_wr", fifo_wr, 0);
    chk("mid_rst_fifo_dat", fifo_dat, 0);
    chk("mid_rst_rd_busy", rd_busy, 0);
    chk("mid_rst_ovf", ovf, 0);
    chk("mid_rst_err", err, 0);
    repeat (2) @(posedge sdram_clk);
    #1 sdram_rst = 1'b0;
    repeat (2) @(posedge sdram_clk); #1;
    rd(16'hCAFE, 16'hF00D, 1'b1, 1'b1);
    repeat (4) @(posedge sdram_clk);
    @(negedge sdram_clk);
    chk("mid_recover_wr", wr_cnt - w0, 1);
    chk("mid_recover_sb", sb.size(), 0);
    chk("mid_recover_ovf", ovf, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/sdr_16_rd_capture.md
# sdr_16_rd_capture

Read-data return stage for the 16-bit SDR SDRAM controller, directly downstream of the SDRAM command FSM. It tracks each read-command strobe from the FSM through the command register, CAS latency and input pad register. It captures the two 16-bit beats of each burst-of-2 and packs them into one 32-bit word. The word is pushed into the egress FIFO, with an optional skid buffer to absorb egress back-pressure, since SDRAM reads cannot be stalled.

## Interface
Parameters:
- cl, 2, CAS latency programmed into the SDRAM mode register; legal values 2, 3.
- in_lat, 1, number of input register stages between the dq pins and dq_i; legal values 0..2.
- skid_depth, 4, skid buffer entries; power of two; used only when the skid buffer is compiled in.

Ports:
- sdram_clk, input, 1, controller clock.
- sdram_rst, input, 1, asynchronous active-high reset.
- cmd_read, input, 1, from FSM; high one cycle per read command; the command appears on the SDRAM pins one cycle later.
- dq_i, input, 16, SDRAM read data after in_lat register stages.
- fifo_full, input, 1, egress FIFO full.
- ovf_clr, input, 1, clears the overflow and protocol-error flags.
- fifo_wr, output, 1, egress FIFO write strobe.
- fifo_dat, output, 32, egress FIFO write data.
- rd_busy, output, 1, a read is in the pipeline or the skid buffer is non-empty.
- ovf, output, 1, sticky flag: a word was lost.
- err, output, 1, sticky flag: cmd_read spacing violation.

## Operation
- Delay line: a shift register of length L = 1 + cl + in_lat carries cmd_read. Its tap L marks beat0 on dq_i, and tap L+1 marks beat1.
- Capture: at the beat0 edge, dq_i is stored in the high half. At the beat1 edge, the word {hi, dq_i} is complete.
- Spacing rule: legal cmd_read pulses are at least 2 cycles apart, because the FSM issues reads on even counter values.
  - A pulse in the cycle immediately after another pulse sets err.
  - That second pulse is discarded and gets no capture.
- Without the skid buffer (see Configuration):
  - A completed word is written when fifo_full is low.
  - When fifo_full is high, the word is dropped and ovf is set.
- With the skid buffer:
  - Completed words enter a skid_depth FIFO.
  - The head is written to the egress FIFO on each cycle that fifo_full is low and the buffer is non-empty.
  - When a word completes in the same cycle that the head drains, the head is written and the new word is pushed.
  - When the buffer is full with no drain in that cycle, the new word is dropped and ovf is set; the buffer contents are unchanged.
  - Occupancy pointers wrap modulo skid_depth; the occupancy counter is log2(skid_depth)+1 bits wide.
- ovf_clr clears ovf and err on the next edge. If a set event and ovf_clr occur in the same cycle, the set wins.
- rd_busy is the OR of all delay-line taps and the capture-in-progress flag; with the skid buffer compiled in, it also includes buffer non-empty.
- Reset, including reset in the middle of a burst, clears the delay line, any partial word, the skid buffer and all flags. In-flight data is discarded and no write is issued for it.

## Timing
- Reset values: fifo_wr=0, fifo_dat=0, rd_busy=0, ovf=0, err=0.
- Timing reference: cmd_read is sampled high at edge T.
  - beat0 is sampled at edge T+L.
  - beat1 is sampled at edge T+L+1.
- Without the skid buffer: fifo_wr and fifo_dat are registered at edge T+L+1 and valid for one cycle. fifo_full is sampled in that same cycle.
- With the skid buffer: the word earliest appears at the output one cycle later, at T+L+2. fifo_wr is registered and is qualified by the fifo_full value of the previous cycle, so fifo_dat is held stable while fifo_wr is high.
- Sustained throughput: one 32-bit word every 2 cycles.
- fifo_dat holds its last value when fifo_wr is low.

## Configuration
- Macro SDR16_RD_SKID_EN.
- Defined: the skid_depth buffer is present and output latency is L+2.
- Undefined: there is no buffer, output latency is L+1, any word that meets fifo_full high is dropped with ovf set, and the skid_depth parameter is ignored.

## Test plan
- Single read with cl=2, in_lat=1 (L=4): cmd_read at edge 10, dq_i=16'hA5A5 at edge 14, dq_i=16'h5A5A at edge 15 -> fifo_wr at edge 15 (no skid) or edge 16 (skid) with fifo_dat=32'hA5A55A5A; ovf=0, err=0.
- Back-to-back reads: cmd_read every 2 cycles, 8 times, with an incrementing dq_i -> 8 fifo_wr pulses 2 cycles apart, words in order, no ovf.
- Back-pressure with the skid buffer: fifo_full high for 10 cycles during 6 reads -> first 4 words buffered, words 5 and 6 dropped with ovf=1; after fifo_full falls, exactly 4 writes in order; ovf_clr then clears ovf to 0.
- Back-pressure without the skid buffer: fifo_full high during the beat1 cycle -> no fifo_wr and ovf=1.
- Protocol violation: cmd_read high at edges 20 and 21 -> err=1 and only one word produced.
- Reset mid-operation: sdram_rst asserted between beat0 and beat1 -> no fifo_wr, all outputs 0, and the next legal read is captured correctly.
